apb_timer_slave: RTL and testbench



---
 rtl/apb_timer_slave.sv | 218 +++++++++++++++++++++
 tb/tb_apb_timer_slave.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/apb_timer_slave.sv
// APB2 zero-wait-state timer peripheral: prescaled down-counter with one-shot or
// auto-reload operation, sticky expiry flag and level interrupt.
module apb_timer_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  IRQ
);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_VALUE  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    auto_reload_r;
    logic                    auto_reload_nxt_s;
    logic                    irq_en_r;
    logic                    irq_en_nxt_s;
    logic [7:0]              prescale_r;
    logic [7:0]              prescale_nxt_s;
    logic [7:0]              pcnt_r;
    logic [7:0]              pcnt_nxt_s;
    logic [DATA_WIDTH-1:0]   load_r;
    logic [DATA_WIDTH-1:0]   load_nxt_s;
    logic [DATA_WIDTH-1:0]   value_r;
    logic [DATA_WIDTH-1:0]   value_nxt_s;
    logic                    expired_r;
    logic                    expired_nxt_s;
    logic [DATA_WIDTH-1:0]   prdata_r;
    logic [DATA_WIDTH-1:0]   prdata_nxt_s;
    logic [DATA_WIDTH-1:0]   rdata_s;
    logic                    irq_r;

    logic                    wr_s;
    logic                    rd_setup_s;
    logic [1:0]              reg_sel_s;
    logic                    wr_ctrl_s;
    logic                    wr_load_s;
    logic                    wr_status_s;
    logic                    running_s;
    logic                    tick_s;
    logic                    expire_s;
    logic                    unused_addr_s;

    assign reg_sel_s     = PADDR[3:2];
    assign unused_addr_s = ^{PADDR[ADDR_WIDTH-1:4], PADDR[1:0]};

    assign wr_s        = PSEL & PENABLE & PWRITE;
    assign rd_setup_s  = PSEL & ~PENABLE & ~PWRITE;
    assign wr_ctrl_s   = wr_s & (reg_sel_s == REG_CTRL);
    assign wr_load_s   = wr_s & (reg_sel_s == REG_LOAD);
    assign wr_status_s = wr_s & (reg_sel_s == REG_STATUS);

    assign running_s = (state_r == ST_RUNNING);
    assign tick_s    = running_s & (pcnt_r == prescale_r);
    // A LOAD write on the same edge overrides the tick, so it can never expire.
    assign expire_s  = tick_s & ~wr_load_s & (value_r == DATA_ZERO);

    // Run/stop state: the written EN wins over a simultaneous one-shot expiry.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_STOPPED: begin
                if (wr_ctrl_s && PWDATA[0]) begin
                    state_nxt_s = ST_RUNNING;
                end else begin
                    state_nxt_s = ST_STOPPED;
                end
            end
            ST_RUNNING: begin
                if (wr_ctrl_s) begin
                    state_nxt_s = PWDATA[0] ? ST_RUNNING : ST_STOPPED;
                end else if (expire_s && !auto_reload_r) begin
                    state_nxt_s = ST_STOPPED;
                end else begin
                    state_nxt_s = ST_RUNNING;
                end
            end
            default: begin
                state_nxt_s = ST_STOPPED;
            end
        endcase
    end

    // Control fields, prescaler, counter and expiry flag next-state.
    always_comb begin
        auto_reload_nxt_s = auto_reload_r;
        irq_en_nxt_s      = irq_en_r;
        prescale_nxt_s    = prescale_r;
        load_nxt_s        = load_r;
        value_nxt_s       = value_r;
        pcnt_nxt_s        = pcnt_r;
        expired_nxt_s     = expired_r;

        if (wr_ctrl_s) begin
            auto_reload_nxt_s = PWDATA[1];
            irq_en_nxt_s      = PWDATA[2];
            prescale_nxt_s    = PWDATA[15:8];
        end else begin
            auto_reload_nxt_s = auto_reload_r;
            irq_en_nxt_s      = irq_en_r;
            prescale_nxt_s    = prescale_r;
        end

        if (!running_s || wr_load_s || tick_s) begin
            pcnt_nxt_s = 8'd0;
        end else begin
            pcnt_nxt_s = pcnt_r + 8'd1;
        end

        if (wr_load_s) begin
            load_nxt_s  = PWDATA;
            value_nxt_s = PWDATA;
        end else if (tick_s) begin
            if (value_r != DATA_ZERO) begin
                value_nxt_s = value_r - DATA_ONE;
            end else if (auto_reload_r) begin
                value_nxt_s = load_r;
            end else begin
                value_nxt_s = value_r;
            end
        end else begin
            value_nxt_s = value_r;
        end

        // Set has priority over write-1-to-clear.
        if (expire_s) begin
            expired_nxt_s = 1'b1;
        end else if (wr_status_s && PWDATA[0]) begin
            expired_nxt_s = 1'b0;
        end else begin
            expired_nxt_s = expired_r;
        end
    end

    // Read mux; unimplemented bits read as zero.
    always_comb begin
        rdata_s = DATA_ZERO;
        case (reg_sel_s)
            REG_CTRL: begin
                rdata_s[0]    = running_s;
                rdata_s[1]    = auto_reload_r;
                rdata_s[2]    = irq_en_r;
                rdata_s[15:8] = prescale_r;
            end
            REG_LOAD: begin
                rdata_s = load_r;
            end
            REG_VALUE: begin
                rdata_s = value_r;
            end
            REG_STATUS: begin
                rdata_s[0] = expired_r;
            end
            default: begin
                rdata_s = DATA_ZERO;
            end
        endcase
    end

    // Read data is captured in the setup phase and held until the next read setup.
    always_comb begin
        if (rd_setup_s) begin
            prdata_nxt_s = rdata_s;
        end else begin
            prdata_nxt_s = prdata_r;
        end
    end

    // State registers; IRQ is registered from next-state so it tracks EXPIRED & IRQ_EN.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r       <= ST_STOPPED;
            auto_reload_r <= 1'b0;
            irq_en_r      <= 1'b0;
            prescale_r    <= 8'd0;
            pcnt_r        <= 8'd0;
            load_r        <= DATA_ZERO;
            value_r       <= DATA_ZERO;
            expired_r     <= 1'b0;
            prdata_r      <= DATA_ZERO;
            irq_r         <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            auto_reload_r <= auto_reload_nxt_s;
            irq_en_r      <= irq_en_nxt_s;
            prescale_r    <= prescale_nxt_s;
            pcnt_r        <= pcnt_nxt_s;
            load_r        <= load_nxt_s;
            value_r       <= value_nxt_s;
            expired_r     <= expired_nxt_s;
            prdata_r      <= prdata_nxt_s;
            irq_r         <= expired_nxt_s & irq_en_nxt_s;
        end
    end

    assign PRDATA = prdata_r;
    assign IRQ    = irq_r;

endmodule

// File: tb/tb_apb_timer_slave.sv
// Bench for apb_timer_slave: register-access vector table plus hand-timed
// sequences for auto-reload, write/tick collisions and reset during a transfer.
module tb_apb_timer_slave;

    logic        HCLK;
    logic        HRESETn;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        IRQ;

    int total;
    int bad;
    logic [31:0] exp_q[$];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        bit          exp_irq;
    } vec_t;

    vec_t tbl[22];

    apb_timer_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PADDR   (PADDR),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .IRQ     (IRQ)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the commit edge.
    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(negedge HCLK);
        PENABLE = 1'b1;
        @(negedge HCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, input logic [31:0] e, input string nm);
        exp_q.push_back(e);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(negedge HCLK);
        PENABLE = 1'b1;
        check(nm, PRDATA, exp_q.pop_front());
        @(negedge HCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Start counting from start_val and hit the very first tick with a LOAD write.
    task automatic load_on_tick(input logic [31:0] start_val);
        apb_write(32'h0, 32'h0000_0000);
        apb_write(32'hC, 32'h0000_0001);
        apb_write(32'h4, start_val);
        apb_write(32'h0, 32'h0000_0301);
        repeat (2) @(negedge HCLK);
        apb_write(32'h4, 32'h0000_0100);
        apb_read(32'h8, 32'h0000_0100, "lot_value");
        apb_read(32'hC, 32'h0000_0000, "lot_status");
        apb_read(32'h0, 32'h0000_0301, "lot_ctrl");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        HRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 32'h0; PWDATA = 32'h0;

        //           wr    addr          data           exp            irq
        tbl[0]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0};
        tbl[1]  = '{1'b0, 32'h0000_0004, 32'h0,         32'h0000_0000, 1'b0};
        tbl[2]  = '{1'b0, 32'h0000_0008, 32'h0,         32'h0000_0000, 1'b0};
        tbl[3]  = '{1'b0, 32'h0000_000C, 32'h0,         32'h0000_0000, 1'b0};
        tbl[4]  = '{1'b1, 32'h0000_0004, 32'h0000_0005, 32'h0,         1'b0};
        tbl[5]  = '{1'b1, 32'h0000_0000, 32'h0000_0005, 32'h0,         1'b0};
        tbl[6]  = '{1'b0, 32'h0000_0008, 32'h0,         32'h0000_0005, 1'b0};
        tbl[7]  = '{1'b0, 32'h0000_0008, 32'h0,         32'h0000_0003, 1'b0};
        tbl[8]  = '{1'b0, 32'h0000_0008, 32'h0,         32'h0000_0001, 1'b1};
        tbl[9]  = '{1'b0, 32'h0000_000C, 32'h0,         32'h0000_0001, 1'b1};
        tbl[10] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_0004, 1'b1};
        tbl[11] = '{1'b0, 32'h0000_0004, 32'h0,         32'h0000_0005, 1'b1};
        tbl[12] = '{1'b1, 32'h0000_000C, 32'h0000_0000, 32'h0,         1'b1};
        tbl[13] = '{1'b0, 32'h0000_000C, 32'h0,         32'h0000_0001, 1'b1};
        tbl[14] = '{1'b1, 32'h0000_000C, 32'h0000_0001, 32'h0,         1'b0};
        tbl[15] = '{1'b0, 32'h0000_000C, 32'h0,         32'h0000_0000, 1'b0};
        tbl[16] = '{1'b1, 32'h0000_0000, 32'hFFFF_AAF6, 32'h0,         1'b0};
        tbl[17] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_AA06, 1'b0};
        tbl[18] = '{1'b1, 32'h0000_0010, 32'h0000_0400, 32'h0,         1'b0};
        tbl[19] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_0400, 1'b0};
        tbl[20] = '{1'b1, 32'h0000_0008, 32'h0000_1234, 32'h0,         1'b0};
        tbl[21] = '{1'b0, 32'h0000_0008, 32'h0,         32'h0000_0000, 1'b0};

        repeat (3) @(negedge HCLK);
        check("reset_prdata", PRDATA, 32'h0);
        check("reset_irq", {31'h0, IRQ}, 32'h0);
        HRESETn = 1'b1;
        @(negedge HCLK);

        for (int i = 0; i < 22; i++) begin
            if (tbl[i].wr) begin
                apb_write(tbl[i].addr, tbl[i].data);
            end else begin
                apb_read(tbl[i].addr, tbl[i].exp, $sformatf("vec%0d_rd", i));
            end
            check($sformatf("vec%0d_irq", i), {31'h0, IRQ}, {31'h0, tbl[i].exp_irq});
        end

        // Auto-reload, PRESCALE=3: reads every 2 cycles see each value twice.
        apb_write(32'h4, 32'h0000_0002);
        apb_write(32'h0, 32'h0000_0303);
        for (int k = 0; k < 12; k++) begin
            apb_read(32'h8, 32'(2 - ((k / 2) % 3)), $sformatf("ar_value%0d", k));
        end
        apb_write(32'hC, 32'h0000_0001);
        apb_read(32'hC, 32'h0000_0000, "ar_cleared");
        repeat (8) @(negedge HCLK);
        apb_read(32'hC, 32'h0000_0001, "ar_reexpired");
        apb_read(32'h0, 32'h0000_0303, "ar_en_kept");
        repeat (6) @(negedge HCLK);
        apb_write(32'hC, 32'h0000_0001);
        apb_read(32'hC, 32'h0000_0001, "w1c_vs_expiry");

        load_on_tick(32'h0000_0007);
        load_on_tick(32'h0000_0000);

        // Get IRQ high and PRDATA non-zero, then reset in the middle of a LOAD write.
        apb_write(32'h0, 32'h0000_0000);
        apb_write(32'hC, 32'h0000_0001);
        apb_write(32'h4, 32'h0000_0000);
        apb_write(32'h0, 32'h0000_0005);
        @(negedge HCLK);
        apb_read(32'hC, 32'h0000_0001, "pre_rst_status");
        check("pre_rst_irq", {31'h0, IRQ}, 32'h1);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h4; PWDATA = 32'h0000_00AA;
        @(negedge HCLK);
        PENABLE = 1'b1;
        #2 HRESETn = 1'b0;
        #1;
        check("rst_prdata", PRDATA, 32'h0);
        check("rst_irq", {31'h0, IRQ}, 32'h0);
        @(negedge HCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        HRESETn = 1'b1;
        @(negedge HCLK);
        apb_read(32'h4, 32'h0000_0000, "rst_load");
        apb_read(32'h8, 32'h0000_0000, "rst_value");
        apb_read(32'hC, 32'h0000_0000, "rst_status");
        apb_read(32'h0, 32'h0000_0000, "rst_ctrl");
        check("rst_irq_after", {31'h0, IRQ}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
